instr_encoder_loader: RTL and testbench

- Encoder side of the pipeline's instruction decode: takes symbolic instructions (op class plus fields) over a valid/ready stream and packs them into 32-bit LEGv8 instruction words.
- Writes each packed word sequentially into instruction memory through a write port.
- Used by the testbench/boot loader to program instruction memory before the 5-stage core runs.
- Encodings are exactly those the core's decoder recognises.

---
 rtl/instr_encoder_loader.sv | 119 +++++++++++
 tb/tb_instr_encoder_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Packs symbolic LEGv8 instructions from a valid/ready stream into 32-bit words
// and writes them sequentially into instruction memory, one word per transfer.
module instr_encoder_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rn,
    input  logic [4:0]        rm,
    input  logic [11:0]       imm12,
    input  logic [5:0]        shamt,
    input  logic [8:0]        daddr9,
    input  logic [25:0]       baddr26,
    input  logic [18:0]       caddr19,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              full,
    output logic              err_illegal
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FULL
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADDI = 4'd1,
        OP_ADDS = 4'd2,
        OP_SUBS = 4'd3,
        OP_LSL  = 4'd4,
        OP_LSR  = 4'd5,
        OP_MUL  = 4'd6,
        OP_B    = 4'd7,
        OP_BLT  = 4'd8,
        OP_CBZ  = 4'd9,
        OP_LDUR = 4'd10,
        OP_STUR = 4'd11
    } op_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t      state;
    logic [31:0] enc;
    logic        legal;
    logic        xfer;

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (op_t'(op))
            OP_NOP:  enc = '0;
            OP_ADDI: enc = {10'b1001000100, imm12, rn, rd};
            OP_ADDS: enc = {11'b10101011000, rm, 6'd0, rn, rd};
            OP_SUBS: enc = {11'b11101011000, rm, 6'd0, rn, rd};
            OP_MUL:  enc = {11'b10011011000, rm, 6'd0, rn, rd};
            OP_LSL:  enc = {11'b11010011011, 5'd0, shamt, rn, rd};
            OP_LSR:  enc = {11'b11010011010, 5'd0, shamt, rn, rd};
            OP_B:    enc = {6'b000101, baddr26};
            OP_BLT:  enc = {8'b01010100, caddr19, 5'b01011};
            OP_CBZ:  enc = {8'b10110100, caddr19, rd};
            OP_LDUR: enc = {11'b11111000010, daddr9, 2'b00, rn, rd};
            OP_STUR: enc = {11'b11111000000, daddr9, 2'b00, rn, rd};
            default: legal = 1'b0;
        endcase
    end

    // word_count advances on the capture edge, so it already includes the
    // word being written and serves directly as the next capture address.
    assign in_ready = (state == LOAD) && (word_count < DEPTH_W);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state != IDLE) || imem_we;
    assign full     = (state == FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            word_count  <= '0;
            err_illegal <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (xfer && legal) begin
                imem_we    <= 1'b1;
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= enc;
                word_count <= word_count + 1'b1;
            end
            if (xfer && !legal)
                err_illegal <= 1'b1;

            // start outranks finish, the count increment and the error flag
            if (start) begin
                state       <= LOAD;
                word_count  <= '0;
                err_illegal <= 1'b0;
            end else if (finish && state != IDLE) begin
                state <= IDLE;
            end else if (state == LOAD && xfer && legal
                         && (word_count + 1'b1) == DEPTH_W) begin
                state <= FULL;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: golden encoding table, hand sequences for
// session corners, and randomized traffic against a transaction-level model.
module tb_instr_encoder_loader;

    localparam int AW = 3;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          reset, start, finish, in_valid;
    logic          in_ready;
    logic [3:0]    op;
    logic [4:0]    rd, rn, rm;
    logic [11:0]   imm12;
    logic [5:0]    shamt;
    logic [8:0]    daddr9;
    logic [25:0]   baddr26;
    logic [18:0]   caddr19;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          busy, full, err_illegal;

    int tests = 0;
    int fails = 0;

    instr_encoder_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .rd(rd), .rn(rn), .rm(rm), .imm12(imm12), .shamt(shamt),
        .daddr9(daddr9), .baddr26(baddr26), .caddr19(caddr19),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .word_count(word_count), .busy(busy), .full(full),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd, rn, rm;
        logic [11:0] imm12;
        logic [5:0]  shamt;
        logic [8:0]  daddr9;
        logic [25:0] baddr26;
        logic [18:0] caddr19;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    // Session-level model: the list of words written and the session flags.
    bit          m_active, m_err, m_we;
    int          m_count;
    logic [31:0] m_addr, m_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_enc();
        logic [31:0] opc;
        case (op)
            4'd1: return (32'h244 << 22) | (32'(imm12) << 10) | (32'(rn) << 5) | 32'(rd);
            4'd2, 4'd3, 4'd6: begin
                opc = (op == 4'd2) ? 32'h558 : (op == 4'd3) ? 32'h758 : 32'h4D8;
                return (opc << 21) | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd);
            end
            4'd4, 4'd5: begin
                opc = (op == 4'd4) ? 32'h69B : 32'h69A;
                return (opc << 21) | (32'(shamt) << 10) | (32'(rn) << 5) | 32'(rd);
            end
            4'd7: return (32'd5 << 26) | 32'(baddr26);
            4'd8: return (32'h54 << 24) | (32'(caddr19) << 5) | 32'd11;
            4'd9: return (32'hB4 << 24) | (32'(caddr19) << 5) | 32'(rd);
            4'd10, 4'd11: begin
                opc = (op == 4'd10) ? 32'h7C2 : 32'h7C0;
                return (opc << 21) | (32'(daddr9) << 12) | (32'(rn) << 5) | 32'(rd);
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_active = 0; m_err = 0; m_we = 0; m_count = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic model_step();
        bit accept;
        accept = in_valid && m_active && (m_count < DP);
        m_we = 0;
        if (accept) begin
            if (op < 4'd12) begin
                m_we = 1; m_addr = 32'(m_count); m_data = ref_enc(); m_count++;
            end else begin
                m_err = 1;
            end
        end
        if (start) begin
            m_active = 1; m_count = 0; m_err = 0;
        end else if (finish) begin
            m_active = 0;
        end
    endtask

    task automatic compare_all();
        check("ready", in_ready, m_active && (m_count < DP));
        check("we", imem_we, m_we);
        check("addr", imem_addr, m_addr);
        check("wdata", imem_wdata, m_data);
        check("count", word_count, m_count);
        check("busy", busy, m_active || m_we);
        check("full", full, m_active && (m_count == DP));
        check("err", err_illegal, m_err);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_fields(input vec_t v);
        op = v.op; rd = v.rd; rn = v.rn; rm = v.rm; imm12 = v.imm12; shamt = v.shamt;
        daddr9 = v.daddr9; baddr26 = v.baddr26; caddr19 = v.caddr19;
    endtask

    task automatic pulse_start();
        start = 1; in_valid = 0; cycle(); start = 0;
    endtask

    initial begin
        int writes;
        tbl[0]  = '{4'd1,  5'd1,  5'd2,  5'd0,  12'd5,   6'h3F, 9'h1AB, 26'h3FFFFFF, 19'd0, 32'h91001441};
        tbl[1]  = '{4'd2,  5'd3,  5'd1,  5'd2,  12'd0,   6'h2A, 9'd0,   26'd0,       19'd0, 32'hAB020023};
        tbl[2]  = '{4'd4,  5'd7,  5'd1,  5'd9,  12'd0,   6'd4,  9'd0,   26'd0,       19'd0, 32'hD3601027};
        tbl[3]  = '{4'd10, 5'd5,  5'd6,  5'd0,  12'hFFF, 6'd0,  9'd8,   26'd0,       19'd0, 32'hF84080C5};
        tbl[4]  = '{4'd7,  5'd31, 5'd31, 5'd0,  12'd0,   6'd0,  9'd0,   26'd3,       19'd0, 32'h14000003};
        tbl[5]  = '{4'd9,  5'd4,  5'd7,  5'd0,  12'hFFF, 6'd0,  9'd0,   26'd0,       19'd2, 32'hB4000044};
        tbl[6]  = '{4'd8,  5'd5,  5'd0,  5'd0,  12'd0,   6'd0,  9'd0,   26'd0,  19'h7FFFF, 32'h54FFFFEB};
        tbl[7]  = '{4'd0,  5'd31, 5'd31, 5'd31, 12'hFFF, 6'h3F, 9'h1FF, 26'h3FFFFFF, 19'h7FFFF, 32'h00000000};
        tbl[8]  = '{4'd3,  5'd1,  5'd2,  5'd3,  12'd0,   6'd0,  9'd0,   26'd0,       19'd0, 32'hEB030041};
        tbl[9]  = '{4'd6,  5'd1,  5'd2,  5'd3,  12'd0,   6'd5,  9'd0,   26'd0,       19'd0, 32'h9B030041};
        tbl[10] = '{4'd5,  5'd2,  5'd3,  5'd31, 12'd0,   6'h3F, 9'd0,   26'd0,       19'd0, 32'hD340FC62};
        tbl[11] = '{4'd11, 5'd1,  5'd2,  5'd0,  12'h7FF, 6'd0,  9'h1FF, 26'd0,       19'd0, 32'hF81FF041};

        reset = 1; start = 0; finish = 0; in_valid = 0;
        set_fields(tbl[7]);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_outputs", {in_ready, imem_we, busy, full, err_illegal}, 5'b0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_count", word_count, 0);
        reset = 0;
        cycle();

        // each golden vector in its own session: written at addr 0, count 1
        for (int i = 0; i < 12; i++) begin
            pulse_start();
            set_fields(tbl[i]);
            in_valid = 1;
            cycle();
            in_valid = 0;
            check("tbl_we", imem_we, 1);
            check("tbl_addr", imem_addr, 0);
            check("tbl_wdata", imem_wdata, tbl[i].exp);
            check("tbl_count", word_count, 1);
        end

        // back-to-back ADDS, LSL, LDUR at consecutive addresses
        pulse_start();
        for (int i = 1; i <= 3; i++) begin
            set_fields(tbl[i]);
            in_valid = 1;
            cycle();
            check("b2b_we", imem_we, 1);
            check("b2b_addr", imem_addr, i - 1);
            check("b2b_wdata", imem_wdata, tbl[i].exp);
        end
        in_valid = 0;
        cycle();

        // fill to DEPTH with NOPs held valid for six cycles
        pulse_start();
        set_fields(tbl[7]);
        in_valid = 1;
        writes = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (imem_we) writes++;
        end
        in_valid = 0;
        cycle();
        check("fill_writes", writes, DP);
        check("fill_full", full, 1);
        check("fill_ready", in_ready, 0);
        check("fill_count", word_count, DP);

        // illegal op between two ADDIs
        pulse_start();
        set_fields(tbl[0]); in_valid = 1;
        cycle();
        op = 4'd13;
        cycle();
        check("ill_no_write", imem_we, 0);
        set_fields(tbl[0]); imm12 = 12'd9;
        cycle();
        in_valid = 0;
        check("ill_addr2", imem_addr, 1);
        check("ill_wdata2", imem_wdata, 32'h91002441);
        repeat (3) cycle();
        check("ill_sticky", err_illegal, 1);
        check("ill_count", word_count, 2);
        pulse_start();
        check("ill_cleared", err_illegal, 0);
        check("ill_count0", word_count, 0);

        // reset while a write strobe is up
        set_fields(tbl[1]); in_valid = 1;
        cycle();
        in_valid = 0;
        check("midrst_we_before", imem_we, 1);
        #2 reset = 1;
        #1;
        model_reset();
        check("midrst_we", imem_we, 0);
        check("midrst_flags", {in_ready, busy, full, err_illegal}, 4'b0);
        check("midrst_count", word_count, 0);
        check("midrst_data", imem_wdata, 0);
        @(posedge clk);
        #1 reset = 0;
        cycle();

        // finish together with a transfer: word still lands, then idle
        pulse_start();
        set_fields(tbl[4]); in_valid = 1; finish = 1;
        cycle();
        in_valid = 0; finish = 0;
        check("fin_we", imem_we, 1);
        check("fin_wdata", imem_wdata, 32'h14000003);
        check("fin_busy", busy, 1);
        check("fin_ready", in_ready, 0);
        cycle();
        check("fin_busy_after", busy, 0);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 14) == 0);
            finish   = ($urandom_range(0, 24) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            op       = 4'($urandom);
            rd = 5'($urandom); rn = 5'($urandom); rm = 5'($urandom);
            imm12 = 12'($urandom); shamt = 6'($urandom); daddr9 = 9'($urandom);
            baddr26 = 26'($urandom); caddr19 = 19'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
